// File: rtl/polymul_pkg.sv
// Shared types and defaults for the bit-serial polynomial multiplier controller.
package polymul_pkg;

  localparam int POLYMUL_N = 4;
  localparam int POLYMUL_K = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/polymul_bitcnt.sv
// Bit-slice counter: counts 0..N-1 while enabled, wraps to 0 after the
// terminal count, and is forced to 0 by clr. tc flags the last slice.
module polymul_bitcnt #(
  parameter  int N = polymul_pkg::POLYMUL_N,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Terminal count is decoded from the register only.
  always_comb begin
    tc = (cnt_q == LAST);
  end

  // Next count: clear wins, otherwise step and wrap on the last slice.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/polymul_ctrl.sv
// Sequencer for a bit-serial polynomial multiplier: IDLE -> LOAD (1 cycle)
// -> RUN (N cycles) -> DONE (until acknowledged). All outputs are decoded
// from the state and bit counter registers, so no input reaches an output
// combinationally.
// Optional build macro POLYMUL_CTRL_PERF_EN adds a saturating 16-bit count
// of completed (acknowledged) operations on port op_count.
module polymul_ctrl
  import polymul_pkg::*;
#(
  parameter  int N = POLYMUL_N,
  parameter  int K = POLYMUL_K,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic         abort,
  output logic         csr_load,
  output logic         csr_shift,
  output logic         acc_clr,
  output logic         acc_en,
  output logic [W-1:0] bit_idx,
  output logic [K-1:0] lane_mask,
  output logic         done,
  input  logic         done_ack
`ifdef POLYMUL_CTRL_PERF_EN
  ,
  output logic [15:0]  op_count
`endif
);

  state_t state_q;
  state_t state_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  // Counter runs only in RUN; anything else (including an abort) parks it at 0.
  always_comb begin
    cnt_en  = (state_q == RUN);
    cnt_clr = (state_q != RUN) || abort;
  end

  polymul_bitcnt #(.N(N)) u_bitcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (bit_idx),
    .tc    (cnt_tc)
  );

  // Next-state logic; abort only matters while an operation is in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !abort) state_d = LOAD;
      LOAD: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          state_d = DONE;
        end
      end
      DONE: if (done_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    ready     = (state_q == IDLE);
    csr_load  = (state_q == LOAD);
    acc_clr   = (state_q == LOAD);
    csr_shift = (state_q == RUN);
    acc_en    = (state_q == RUN);
    lane_mask = {K{state_q == RUN}};
    done      = (state_q == DONE);
  end

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef POLYMUL_CTRL_PERF_EN
  logic [15:0] op_count_q;
  logic [15:0] op_count_d;

  // Count only acknowledged completions, saturating at all-ones.
  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == DONE) && done_ack && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // Completed-operation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_polymul_ctrl.sv
// Scoreboard bench for polymul_ctrl (N=4, K=4). The driver applies inputs
// just after each rising edge and queues the outputs expected for that
// cycle; a monitor samples on the falling edge and compares.
module tb_polymul_ctrl;

  typedef struct packed {
    logic       ready;
    logic       csr_load;
    logic       csr_shift;
    logic       acc_clr;
    logic       acc_en;
    logic [1:0] bit_idx;
    logic [3:0] lane_mask;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       done_ack = 1'b0;
  logic       ready, csr_load, csr_shift, acc_clr, acc_en, done;
  logic [1:0] bit_idx;
  logic [3:0] lane_mask;
`ifdef POLYMUL_CTRL_PERF_EN
  logic [15:0] op_count;
`endif

  obs_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  polymul_ctrl #(.N(4), .K(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ready     (ready),
    .abort     (abort),
    .csr_load  (csr_load),
    .csr_shift (csr_shift),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .bit_idx   (bit_idx),
    .lane_mask (lane_mask),
    .done      (done),
    .done_ack  (done_ack)
`ifdef POLYMUL_CTRL_PERF_EN
    ,
    .op_count  (op_count)
`endif
  );

  function automatic obs_t o_idle();
    obs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_load();
    obs_t o = '0;
    o.csr_load = 1'b1;
    o.acc_clr  = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_run(input int i);
    obs_t o = '0;
    o.csr_shift = 1'b1;
    o.acc_en    = 1'b1;
    o.bit_idx   = 2'(i);
    o.lane_mask = 4'hF;
    return o;
  endfunction

  function automatic obs_t o_done();
    obs_t o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  // One cycle: inputs for the edge that ends this cycle, and the outputs
  // expected while this cycle lasts.
  task automatic cyc(input string nm, input logic r, input logic s,
                     input logic a, input logic ack, input obs_t e);
    @(posedge clk);
    #1;
    reset    = r;
    start    = s;
    abort    = a;
    done_ack = ack;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare sampled outputs against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {ready, csr_load, csr_shift, acc_clr, acc_en, bit_idx, lane_mask, done};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got rdy=%b ld=%b sh=%b clr=%b en=%b idx=%0d mask=%h done=%b, need rdy=%b ld=%b sh=%b clr=%b en=%b idx=%0d mask=%h done=%b",
                 nm, g.ready, g.csr_load, g.csr_shift, g.acc_clr, g.acc_en, g.bit_idx, g.lane_mask, g.done,
                 e.ready, e.csr_load, e.csr_shift, e.acc_clr, e.acc_en, e.bit_idx, e.lane_mask, e.done);
      end else begin
        $display("ok   %s: rdy=%b ld=%b sh=%b idx=%0d mask=%h done=%b",
                 nm, g.ready, g.csr_load, g.csr_shift, g.bit_idx, g.lane_mask, g.done);
      end
    end
  end

  initial begin
    // Held in reset: inputs are ignored.
    cyc("rst_hold_inputs", 1'b0, 1'b1, 1'b1, 1'b1, o_idle());
    cyc("rst_hold",        1'b0, 1'b0, 1'b0, 1'b0, o_idle());
    cyc("rst_release",     1'b1, 1'b0, 1'b0, 1'b0, o_idle());

    // Normal operation; start kept high while busy must not re-trigger.
    cyc("n_start", 1'b1, 1'b1, 1'b0, 1'b0, o_idle());
    cyc("n_load",  1'b1, 1'b1, 1'b0, 1'b0, o_load());
    for (int i = 0; i < 4; i++) cyc("n_run", 1'b1, 1'b1, 1'b0, 1'b0, o_run(i));
    for (int i = 0; i < 3; i++) cyc("n_done_hold", 1'b1, 1'b1, 1'b0, 1'b0, o_done());
    cyc("n_done_ack",   1'b1, 1'b1, 1'b0, 1'b1, o_done());
    cyc("n_idle_ack",   1'b1, 1'b0, 1'b0, 1'b1, o_idle());
    cyc("n_idle",       1'b1, 1'b0, 1'b0, 1'b0, o_idle());

    // Abort at bit_idx=1.
    cyc("a_start", 1'b1, 1'b1, 1'b0, 1'b0, o_idle());
    cyc("a_load",  1'b1, 1'b0, 1'b0, 1'b0, o_load());
    cyc("a_run0",  1'b1, 1'b0, 1'b0, 1'b0, o_run(0));
    cyc("a_run1",  1'b1, 1'b0, 1'b1, 1'b0, o_run(1));
    cyc("a_idle",  1'b1, 1'b0, 1'b0, 1'b0, o_idle());
    cyc("a_idle2", 1'b1, 1'b0, 1'b0, 1'b0, o_idle());

    // Start and abort together in IDLE: abort wins.
    cyc("sa_both", 1'b1, 1'b1, 1'b1, 1'b0, o_idle());
    cyc("sa_idle", 1'b1, 1'b0, 1'b0, 1'b0, o_idle());

    // Abort during LOAD.
    cyc("al_start", 1'b1, 1'b1, 1'b0, 1'b0, o_idle());
    cyc("al_load",  1'b1, 1'b0, 1'b1, 1'b0, o_load());
    cyc("al_idle",  1'b1, 1'b0, 1'b0, 1'b0, o_idle());

    // Abort in DONE is ignored.
    cyc("ad_start", 1'b1, 1'b1, 1'b0, 1'b0, o_idle());
    cyc("ad_load",  1'b1, 1'b0, 1'b0, 1'b0, o_load());
    for (int i = 0; i < 4; i++) cyc("ad_run", 1'b1, 1'b0, 1'b0, 1'b0, o_run(i));
    cyc("ad_abort", 1'b1, 1'b0, 1'b1, 1'b0, o_done());
    cyc("ad_ack",   1'b1, 1'b0, 1'b0, 1'b1, o_done());
    cyc("ad_idle",  1'b1, 1'b0, 1'b0, 1'b0, o_idle());

    // Reset asserted mid-RUN at bit_idx=2 takes effect before the next edge.
    cyc("r_start", 1'b1, 1'b1, 1'b0, 1'b0, o_idle());
    cyc("r_load",  1'b1, 1'b0, 1'b0, 1'b0, o_load());
    cyc("r_run0",  1'b1, 1'b0, 1'b0, 1'b0, o_run(0));
    cyc("r_run1",  1'b1, 1'b0, 1'b0, 1'b0, o_run(1));
    cyc("r_mid",   1'b0, 1'b0, 1'b0, 1'b0, o_idle());
    cyc("r_hold",  1'b0, 1'b0, 1'b0, 1'b0, o_idle());
    // First start after release is accepted on the first edge.
    cyc("r_rel_start", 1'b1, 1'b1, 1'b0, 1'b0, o_idle());
    cyc("r_load2",     1'b1, 1'b0, 1'b0, 1'b0, o_load());
    for (int i = 0; i < 4; i++) cyc("r_run", 1'b1, 1'b0, 1'b0, 1'b0, o_run(i));
    cyc("r_ack",  1'b1, 1'b0, 1'b0, 1'b1, o_done());
    cyc("r_idle", 1'b1, 1'b0, 1'b0, 1'b0, o_idle());

    // Let the last expectation drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end

`ifdef POLYMUL_CTRL_PERF_EN
    // One completion after the mid-RUN reset cleared the counter.
    n_cmp++;
    if (op_count !== 16'd1) begin
      n_err++;
      $display("FAIL op_count: got %0d need 1", op_count);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
